// File: rtl/prio_deco_pkg.sv
// Shared widths and the 3-to-8 one-hot decode used by the buffered decoder.
// Ports: none (package only).
// Latency: n/a. Backpressure: n/a.
package prio_deco_pkg;

  localparam int CODE_W   = 3;
  localparam int ONEHOT_W = 8;

  // One-hot decode of a binary index; exactly one bit set for any legal code.
  function automatic logic [ONEHOT_W-1:0] decode3x8(input logic [CODE_W-1:0] code);
    logic [ONEHOT_W-1:0] v;
    v       = '0;
    v[code] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/prio_deco_3x8_if.sv
// Bundle of the code-in / one-hot-out handshake plus seen/count status.
// Ports: d_in/in_valid/in_ready (push side), d_out/out_valid/out_ready (pop side),
//        seen/clr_seen (sticky history), count (occupancy). master = driver, slave = decoder.
interface prio_deco_3x8_if #(
  parameter int DEPTH = 4
);
  import prio_deco_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [CODE_W-1:0]   d_in;
  logic                in_valid;
  logic                in_ready;
  logic [ONEHOT_W-1:0] d_out;
  logic                out_valid;
  logic                out_ready;
  logic [ONEHOT_W-1:0] seen;
  logic                clr_seen;
  logic [CNT_W-1:0]    count;

  modport master (
    output d_in, in_valid, out_ready, clr_seen,
    input  in_ready, d_out, out_valid, seen, count
  );

  modport slave (
    input  d_in, in_valid, out_ready, clr_seen,
    output in_ready, d_out, out_valid, seen, count
  );

endinterface

// File: rtl/prio_deco_fifo.sv
// Synchronous FIFO with occupancy count; head word is presented combinationally from storage.
// Ports: clk/rst_n, write side i_wr_vld/o_wr_rdy/i_wr_dat, read side o_rd_vld/i_rd_rdy/o_rd_dat, o_count.
// Latency 1 cycle write-to-read; o_wr_rdy depends only on count (full refuses even during a pop).
module prio_deco_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 3,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr_vld,
  output logic             o_wr_rdy,
  input  logic [W-1:0]     i_wr_dat,
  output logic             o_rd_vld,
  input  logic             i_rd_rdy,
  output logic [W-1:0]     o_rd_dat,
  output logic [CNT_W-1:0] o_count
);

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_push;
  logic w_pop;

  assign o_wr_rdy = (r_count != CNT_FULL);
  assign o_rd_vld = (r_count != '0);
  assign o_rd_dat = r_mem[r_rd_ptr];
  assign o_count  = r_count;

  assign w_push = i_wr_vld & o_wr_rdy;
  // Popping an empty FIFO is impossible because o_rd_vld gates it.
  assign w_pop  = o_rd_vld & i_rd_rdy;

  // Storage is never reset; only pointers/count define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wr_dat;
    end
  end

  // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/prio_deco_3x8.sv
// Buffered 3-to-8 decoder: queues codes, presents the head as one-hot, keeps a sticky OR of popped values.
// Ports: clk, rst_n, bus (slave modport: d_in/in_valid/in_ready, d_out/out_valid/out_ready, seen/clr_seen, count).
// Latency 1 cycle into an empty buffer; in_ready drops at full regardless of out_ready, d_out holds while stalled.
module prio_deco_3x8
  import prio_deco_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  prio_deco_3x8_if.slave    bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [CODE_W-1:0]   w_head;
  logic                w_head_vld;
  logic [CNT_W-1:0]    w_count;
  logic                w_wr_rdy;
  logic                w_pop;
  logic [ONEHOT_W-1:0] w_dec;
  logic [ONEHOT_W-1:0] r_seen;

  prio_deco_fifo #(
    .DEPTH (DEPTH),
    .W     (CODE_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_wr_vld (bus.in_valid),
    .o_wr_rdy (w_wr_rdy),
    .i_wr_dat (bus.d_in),
    .o_rd_vld (w_head_vld),
    .i_rd_rdy (bus.out_ready),
    .o_rd_dat (w_head),
    .o_count  (w_count)
  );

  // Forced to zero when empty so stale storage never leaks onto d_out.
  assign w_dec = w_head_vld ? decode3x8(w_head) : '0;
  assign w_pop = w_head_vld & bus.out_ready;

  // Clear takes effect before the OR, so a coincident pop leaves only its own bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seen <= '0;
    end else if (w_pop) begin
      r_seen <= (bus.clr_seen ? '0 : r_seen) | w_dec;
    end else if (bus.clr_seen) begin
      r_seen <= '0;
    end
  end

  assign bus.in_ready  = w_wr_rdy;
  assign bus.out_valid = w_head_vld;
  assign bus.d_out     = w_dec;
  assign bus.count     = w_count;
  assign bus.seen      = r_seen;

endmodule

// File: doc/prio_deco_3x8.md
PRIO_DECO_3X8 -- requirements
Module: prio_deco_3x8

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, number of buffered codes (power of two, >=2).
REQ-002 The block SHALL have port clk, input, 1, the single clock, with all state updating on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, the reset, which is asynchronous and active-low.
REQ-004 The block SHALL have port d_in, input, 3, the encoded index (0..7) to be decoded.
REQ-005 The block SHALL have port in_valid, input, 1, which qualifies d_in.
REQ-006 The block SHALL have port in_ready, output, 1, which indicates the buffer can accept a code.
REQ-007 The block SHALL have port d_out, output, 8, the one-hot decode of the head code.
REQ-008 The block SHALL have port out_valid, output, 1, which qualifies d_out.
REQ-009 The block SHALL have port out_ready, input, 1, the downstream acceptance signal.
REQ-010 The block SHALL have port seen, output, 8, the sticky OR of all transferred d_out values.
REQ-011 The block SHALL have port clr_seen, input, 1, a synchronous clear of seen.
REQ-012 The block SHALL have port count, output, log2(DEPTH)+1, the number of codes held.

Function
REQ-013 Input transfer SHALL occur on an edge where in_valid=1 and in_ready=1; output transfer SHALL occur where out_valid=1 and out_ready=1.
REQ-014 in_ready SHALL equal (count != DEPTH) and SHALL have no combinational dependence on out_ready or in_valid.
REQ-015 Codes SHALL be stored in FIFO order; out_valid SHALL equal (count != 0).
REQ-016 d_out SHALL be 8'b1 << head code when out_valid=1 and SHALL be 8'h00 when out_valid=0; it is never multi-hot.
REQ-017 A code accepted at edge N into an empty buffer SHALL appear on d_out/out_valid immediately after edge N (latency 1 cycle).
REQ-018 Simultaneous input and output transfer SHALL leave count unchanged, including when count=DEPTH-1 or count=1.
REQ-019 When count=DEPTH, input is refused (in_ready=0) even if out_ready=1 in the same cycle; space is visible the cycle after a pop.
REQ-020 When count=0, out_ready SHALL be ignored and no state changes from it.
REQ-021 Read and write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH without gap or duplication.
REQ-022 On each output transfer, seen SHALL become seen | d_out.
REQ-023 When clr_seen=1 coincides with an output transfer, seen SHALL become exactly d_out (clear first, then set); with no transfer, seen SHALL become 8'h00.
REQ-024 Held d_out, out_valid and head code SHALL stay stable while out_valid=1 and out_ready=0.

Reset
REQ-025 While rst_n=0, count, both pointers and seen SHALL be 0, out_valid=0, d_out=8'h00, in_ready=1, regardless of clk.
REQ-026 Reset asserted mid-operation SHALL discard all buffered codes; the first edge after deassertion behaves as from empty.
REQ-027 Storage array contents need not be reset.

Structure
REQ-028 Shared package prio_deco_pkg SHALL hold CODE_W=3, ONEHOT_W=8, and the 3-to-8 decode function.
REQ-029 Buffering SHALL be a sub-module prio_deco_fifo (parameterised sync FIFO with count); decode and seen logic live in prio_deco_3x8.

Verification
REQ-030 Reset, then push 3'd5 with out_ready=0 -> next cycle d_out=8'h20, out_valid=1, count=1, held stable for 5 cycles.
REQ-031 Push 7,6,3,0 with out_ready=0 -> count=4, in_ready=0; 5th push 3'd1 refused; then drain -> d_out 8'h80,8'h40,8'h08,8'h01 in order, seen=8'hC9.
REQ-032 count=1 (code 2), push 3'd4 while popping -> count stays 1, next d_out=8'h10; repeat across 10 cycles to wrap pointers, order intact.
REQ-033 seen=8'h05, clr_seen=1 with transfer of 3'd6 -> seen=8'h40; clr_seen=1 with no transfer -> seen=8'h00.
REQ-034 Buffer holds 3 codes, assert rst_n=0 between edges -> out_valid=0, d_out=8'h00, count=0 immediately; after release push 3'd0 -> d_out=8'h01.
REQ-035 out_ready=1 with empty buffer for 5 cycles -> no transfer, seen and count unchanged.
